// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin front end for a single-transaction SDRAM controller.
// Each port buffers one request; the granted request is held on sd_* until sd_done.
module sdram_arbiter #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              a_we_i,
   input  logic              a_start_i,
   output logic              a_busy_o,
   output logic              a_done_o,
   output logic [DATA_W-1:0] a_q_o,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   input  logic              b_we_i,
   input  logic              b_start_i,
   output logic              b_busy_o,
   output logic              b_done_o,
   output logic [DATA_W-1:0] b_q_o,
   output logic [ADDR_W-1:0] sd_addr_o,
   output logic [DATA_W-1:0] sd_data_o,
   output logic              sd_we_o,
   output logic              sd_start_o,
   input  logic              sd_done_i,
   input  logic [DATA_W-1:0] sd_q_i
);
   typedef enum logic {IDLE, WAIT} state_e;
   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic [ADDR_W-1:0] cap_a_addr_q, cap_a_addr_d, cap_b_addr_q, cap_b_addr_d;
   logic [DATA_W-1:0] cap_a_data_q, cap_a_data_d, cap_b_data_q, cap_b_data_d;
   logic              cap_a_we_q, cap_a_we_d, cap_b_we_q, cap_b_we_d;
   logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
   logic [DATA_W-1:0] sd_data_q, sd_data_d;
   logic              sd_we_q, sd_we_d, sd_start_q, sd_start_d;
   logic              a_done_q, a_done_d, b_done_q, b_done_d;
   logic [DATA_W-1:0] a_q_q, a_q_d, b_q_q, b_q_d;
   logic              a_acc, b_acc, pick_b;

   // grant_q (1 = B) doubles as last_grant; its reset value of B lets A win the first tie
   assign a_busy_o = pend_a_q | ((state_q == WAIT) & ~grant_q);
   assign b_busy_o = pend_b_q | ((state_q == WAIT) & grant_q);
   assign a_acc    = a_start_i & ~a_busy_o;
   assign b_acc    = b_start_i & ~b_busy_o;
   assign pick_b   = pend_b_q & (~pend_a_q | ~grant_q);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      pend_a_d     = pend_a_q | a_acc;
      pend_b_d     = pend_b_q | b_acc;
      cap_a_addr_d = a_acc ? a_addr_i : cap_a_addr_q;
      cap_a_data_d = a_acc ? a_data_i : cap_a_data_q;
      cap_a_we_d   = a_acc ? a_we_i : cap_a_we_q;
      cap_b_addr_d = b_acc ? b_addr_i : cap_b_addr_q;
      cap_b_data_d = b_acc ? b_data_i : cap_b_data_q;
      cap_b_we_d   = b_acc ? b_we_i : cap_b_we_q;
      sd_addr_d    = sd_addr_q;
      sd_data_d    = sd_data_q;
      sd_we_d      = sd_we_q;
      sd_start_d   = 1'b0;
      a_done_d     = 1'b0;
      b_done_d     = 1'b0;
      a_q_d        = a_q_q;
      b_q_d        = b_q_q;
      if (state_q == IDLE) begin
         if (pend_a_q | pend_b_q) begin
            state_d    = WAIT;
            grant_d    = pick_b;
            sd_start_d = 1'b1;
            sd_addr_d  = pick_b ? cap_b_addr_q : cap_a_addr_q;
            sd_data_d  = pick_b ? cap_b_data_q : cap_a_data_q;
            sd_we_d    = pick_b ? cap_b_we_q : cap_a_we_q;
            if (pick_b) pend_b_d = 1'b0;
            else pend_a_d = 1'b0;
         end
      end else if (sd_done_i) begin
         state_d  = IDLE;
         a_done_d = ~grant_q;
         b_done_d = grant_q;
         a_q_d    = grant_q ? a_q_q : sd_q_i;
         b_q_d    = grant_q ? sd_q_i : b_q_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         grant_q      <= 1'b1;
         pend_a_q     <= 1'b0;
         pend_b_q     <= 1'b0;
         cap_a_addr_q <= '0;
         cap_a_data_q <= '0;
         cap_a_we_q   <= 1'b0;
         cap_b_addr_q <= '0;
         cap_b_data_q <= '0;
         cap_b_we_q   <= 1'b0;
         sd_addr_q    <= '0;
         sd_data_q    <= '0;
         sd_we_q      <= 1'b0;
         sd_start_q   <= 1'b0;
         a_done_q     <= 1'b0;
         b_done_q     <= 1'b0;
         a_q_q        <= '0;
         b_q_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         cap_a_addr_q <= cap_a_addr_d;
         cap_a_data_q <= cap_a_data_d;
         cap_a_we_q   <= cap_a_we_d;
         cap_b_addr_q <= cap_b_addr_d;
         cap_b_data_q <= cap_b_data_d;
         cap_b_we_q   <= cap_b_we_d;
         sd_addr_q    <= sd_addr_d;
         sd_data_q    <= sd_data_d;
         sd_we_q      <= sd_we_d;
         sd_start_q   <= sd_start_d;
         a_done_q     <= a_done_d;
         b_done_q     <= b_done_d;
         a_q_q        <= a_q_d;
         b_q_q        <= b_q_d;
      end
   end

   assign sd_addr_o  = sd_addr_q;
   assign sd_data_o  = sd_data_q;
   assign sd_we_o    = sd_we_q;
   assign sd_start_o = sd_start_q;
   assign a_done_o   = a_done_q;
   assign b_done_o   = b_done_q;
   assign a_q_o      = a_q_q;
   assign b_q_o      = b_q_q;
endmodule
